// File: rtl/nn_pkg.sv
// Shared types, widths and the saturating rescale used by the neuron layer.
package nn_pkg;

  localparam int unsigned IW   = 16;
  localparam int unsigned OW   = 32;
  localparam int unsigned FRAC = 8;

  typedef logic signed [IW-1:0] data_t;
  typedef logic signed [OW+1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2
  } state_e;

  localparam acc_t SAT_MAX = acc_t'((64'sd1 <<< (IW - 1)) - 64'sd1);
  localparam acc_t SAT_MIN = acc_t'(-(64'sd1 <<< (IW - 1)));

  // Arithmetic (floor) shift by the weight fraction, then clamp to the data range.
  function automatic data_t sat_shift(acc_t acc, int unsigned frac);
    acc_t sh;
    sh = acc >>> frac;
    if (sh > SAT_MAX) begin
      sat_shift = data_t'(SAT_MAX);
    end else if (sh < SAT_MIN) begin
      sat_shift = data_t'(SAT_MIN);
    end else begin
      sat_shift = data_t'(sh);
    end
  endfunction

endpackage

// File: rtl/nn_mac.sv
// Shared signed multiply-accumulate: one full-precision product per enabled cycle.
module nn_mac
  import nn_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr_i,
  input  logic  en_i,
  input  data_t a_i,
  input  data_t b_i,
  output acc_t  sum_c
);

  logic signed [OW-1:0] prod;
  acc_t                 acc_q;

  // Product is formed at full width so no operand bits are lost.
  assign prod  = OW'(a_i) * OW'(b_i);
  assign sum_c = acc_q + acc_t'(prod);

  // Accumulator register; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_c;
    end
  end

endmodule

// File: rtl/neuron_layer_seq.sv
// Time-multiplexed 4-input neuron layer: one shared MAC walks NN neurons in order.
module neuron_layer_seq
  import nn_pkg::*;
#(
  parameter  int unsigned NN   = 4,
  localparam int unsigned IDXW = (NN > 1) ? $clog2(NN) : 1,
  localparam int unsigned AW   = $clog2(NN * 4)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*IW-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IW-1:0]     out_data,
  output logic [IDXW-1:0]   out_idx,
  output logic              out_last,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [IW-1:0]     cfg_wdata,
  output logic              cfg_ready
);

  state_e          state_q, state_d;
  logic [IDXW-1:0] n_q, n_d;
  logic [1:0]      k_q, k_d;
  logic            out_valid_q, out_valid_d;
  data_t           out_data_q, out_data_d;
  logic [IDXW-1:0] out_idx_q, out_idx_d;
  logic            out_last_q, out_last_d;
  logic            x_load, mac_clr, mac_en;
  logic            cfg_addr_ok, cfg_wr;
  data_t           x_q [4];
  data_t           w_q [NN*4];
  data_t           x_sel, w_sel;
  acc_t            acc_sum;

  assign in_ready  = (state_q == IDLE);
  assign cfg_ready = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

  // Only addresses inside the weight file are writable.
  if (NN * 4 == (1 << AW)) begin : g_addr_full
    assign cfg_addr_ok = 1'b1;
  end else begin : g_addr_part
    assign cfg_addr_ok = (cfg_addr < AW'(NN * 4));
  end
  assign cfg_wr = cfg_we && cfg_ready && cfg_addr_ok;

  // Operand mux: {n,k} is exactly n*4+k because k is two bits wide.
  assign x_sel = x_q[k_q];
  assign w_sel = w_q[{n_q, k_q}];

  nn_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (x_sel),
    .b_i   (w_sel),
    .sum_c (acc_sum)
  );

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  // Input vector capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '{default: '0};
    end else if (x_load) begin
      x_q[0] <= data_t'(in_data[0*IW +: IW]);
      x_q[1] <= data_t'(in_data[1*IW +: IW]);
      x_q[2] <= data_t'(in_data[2*IW +: IW]);
      x_q[3] <= data_t'(in_data[3*IW +: IW]);
    end
  end

  // Weight file; writes land only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '{default: '0};
    end else if (cfg_wr) begin
      w_q[cfg_addr] <= data_t'(cfg_wdata);
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    x_load      = 1'b0;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_load  = 1'b1;
          mac_clr = 1'b1;
          n_d     = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        k_d    = k_q + 2'd1;
        if (k_q == 2'd3) begin
          out_data_d  = sat_shift(acc_sum, FRAC);
          out_idx_d   = n_q;
          out_last_d  = (n_q == IDXW'(NN - 1));
          out_valid_d = 1'b1;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = IDLE;
          end else begin
            n_d     = n_q + IDXW'(1);
            k_d     = '0;
            mac_clr = 1'b1;
            state_d = MAC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Scoreboard bench for neuron_layer_seq: directed vectors, decoupled result monitor.
module tb_neuron_layer_seq;

  localparam int IW = 16;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [4*IW-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [IW-1:0]     out_data;
  logic [1:0]        out_idx;
  logic              out_last;
  logic              cfg_we;
  logic [3:0]        cfg_addr;
  logic [IW-1:0]     cfg_wdata;
  logic              cfg_ready;

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  exp_t          sb[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  bit            have_prev = 0;
  logic [IW-1:0] prev_data;
  logic [1:0]    prev_idx;

  neuron_layer_seq #(.NN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_ready (cfg_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int i, input bit l);
    exp_t e;
    e.data = d;
    e.idx  = i;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic exp4(input int a, input int b, input int c, input int d);
    push(a, 0, 1'b0);
    push(b, 1, 1'b0);
    push(c, 2, 1'b0);
    push(d, 3, 1'b1);
  endtask

  task automatic set_w(input int a, input int v);
    cfg_we    = 1'b1;
    cfg_addr  = 4'(a);
    cfg_wdata = 16'(v);
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic set_identity();
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 4; i++)
        set_w(n * 4 + i, (n == i) ? 256 : 0);
  endtask

  task automatic set_all(input int v);
    for (int a = 0; a < 16; a++) set_w(a, v);
  endtask

  task automatic wait_ready();
    int i;
    i = 0;
    while (!in_ready && i < 300) begin
      step();
      i++;
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  task automatic send(input int a, input int b, input int c, input int d);
    wait_ready();
    in_data  = {16'(d), 16'(c), 16'(b), 16'(a)};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((sb.size() != 0 || !in_ready) && i < 400) begin
      step();
      i++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  // Monitor: pops the scoreboard on each output handshake and checks stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      have_prev = 0;
    end else if (out_valid) begin
      if (have_prev) begin
        check("stall_data_stable", longint'(out_data), longint'(prev_data));
        check("stall_idx_stable", out_idx, prev_idx);
      end
      if (out_ready) begin
        have_prev = 0;
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check("res_data", longint'($signed(out_data)), e.data);
          check("res_idx", out_idx, e.idx);
          check("res_last", out_last, e.last);
        end
      end else begin
        have_prev = 1;
        prev_data = out_data;
        prev_idx  = out_idx;
      end
    end else if (have_prev) begin
      check("stalled_result_dropped", 1, 0);
      have_prev = 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", in_ready, 1);

    // Identity weights with exact latency tracking.
    set_identity();
    exp4(100, -200, 300, -400);
    wait_ready();
    in_data  = {16'(-400), 16'(300), 16'(-200), 16'(100)};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      check($sformatf("lat_out_valid_c%0d", c), out_valid, (c % 5 == 0 && c <= 20) ? 1 : 0);
      check($sformatf("lat_in_ready_c%0d", c), in_ready, (c == 21) ? 1 : 0);
    end
    step();
    drain();

    // Half weights for floor rounding; 7-cycle stall on the first result.
    set_w(0, 128);
    set_w(1, 128);
    exp4(-2, 0, 7, 9);
    out_ready = 1'b0;
    send(-3, 0, 7, 9);
    i = 0;
    while (!out_valid && i < 50) begin
      step();
      i++;
    end
    check("stall_reached_emit", out_valid, 1);
    repeat (7) step();
    out_ready = 1'b1;
    drain();

    // Write attempted during MAC is dropped.
    set_w(0, 256);
    set_w(1, 0);
    exp4(11, 22, 33, 44);
    send(11, 22, 33, 44);
    check("cfg_ready_in_mac", cfg_ready, 0);
    set_w(0, 512);
    drain();
    exp4(1000, 0, 0, 0);
    send(1000, 0, 0, 0);
    drain();

    // Write together with in_valid in IDLE is used by that vector.
    exp4(2000, 5, 0, 0);
    wait_ready();
    cfg_we    = 1'b1;
    cfg_addr  = 4'd0;
    cfg_wdata = 16'd512;
    in_data   = {16'(0), 16'(0), 16'(5), 16'(1000)};
    in_valid  = 1'b1;
    step();
    cfg_we    = 1'b0;
    in_valid  = 1'b0;
    drain();

    // Saturation at both rails.
    set_all(32767);
    exp4(32767, 32767, 32767, 32767);
    send(32767, 32767, 32767, 32767);
    drain();
    exp4(-32768, -32768, -32768, -32768);
    send(-32768, -32768, -32768, -32768);
    drain();

    // Reset during neuron 2: only neurons 0 and 1 may appear.
    push(1279, 0, 1'b0);
    push(1279, 1, 1'b0);
    send(1, 2, 3, 4);
    i = 0;
    while (!(out_valid && out_idx == 2'd1) && i < 50) begin
      step();
      i++;
    end
    check("reached_idx1", (out_valid && out_idx == 2'd1) ? 1 : 0, 1);
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_cfg_ready", cfg_ready, 1);
    check("midrst_out_idx", out_idx, 0);
    step();
    rst_n = 1'b1;
    step();
    check("midrst_sb_empty", sb.size(), 0);
    exp4(0, 0, 0, 0);
    send(500, -600, 700, -800);
    drain();
    set_identity();
    exp4(7, -8, 9, -10);
    send(7, -8, 9, -10);
    drain();

    repeat (5) step();
    check("final_no_extra_valid", out_valid, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
